// File: rtl/ex_muldiv.sv
// Iterative RV64M execute unit: shift-add multiply and restoring divide.
// Ops are accepted and returned through valid/ready handshakes, and busy stalls ID/EX.
module ex_muldiv #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic            word,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [XLEN-1:0] pc_in,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] pc_out,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state, state_next;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opb;
  logic [CNT_W-1:0]  cnt, last;
  logic [2:0]        op_q;
  logic              word_q, neg_res, neg_rem;
  logic [XLEN-1:0]   pc_q;

  logic              is_div, signed1, signed2, neg1, neg2;
  logic              div_zero, ovf, special, accept;
  logic [XLEN-1:0]   ext1, ext2, mag1, mag2, min_neg, spec_res;

  // Operand decode at accept: width/sign extension, magnitudes and bypass detection.
  always_comb begin
    is_div  = op[2];
    signed1 = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
    signed2 = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    ext1 = src1;
    ext2 = src2;
    if (word) begin
      ext1 = signed1 ? {{(XLEN-32){src1[31]}}, src1[31:0]} : {{(XLEN-32){1'b0}}, src1[31:0]};
      ext2 = signed2 ? {{(XLEN-32){src2[31]}}, src2[31:0]} : {{(XLEN-32){1'b0}}, src2[31:0]};
    end
    neg1 = signed1 && ext1[XLEN-1];
    neg2 = signed2 && ext2[XLEN-1];
    mag1 = neg1 ? -ext1 : ext1;
    mag2 = neg2 ? -ext2 : ext2;
    min_neg = word ? {{(XLEN-31){1'b1}}, {31{1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    div_zero = is_div && (ext2 == '0);
    ovf = is_div && !op[0] && (ext1 == min_neg) && (ext2 == '1);
    special = div_zero || ovf;
    spec_res = '0;
    if (div_zero)
      spec_res = op[1] ? (word ? {{(XLEN-32){src1[31]}}, src1[31:0]} : src1) : '1;
    else if (ovf)
      spec_res = op[1] ? '0 : ext1;
    accept = in_valid && (state == IDLE) && !flush;
  end

  logic [XLEN:0]     mul_sum, mul_hi, div_shift;
  logic [XLEN+1:0]   div_diff;
  logic              div_ge;
  logic [XLEN-1:0]   div_rem;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, sel;

  // One shift-add or restoring-divide step, plus the final sign fix-up and half select.
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opb};
    mul_hi    = acc[0] ? mul_sum : {1'b0, acc[2*XLEN-1:XLEN]};
    div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opb};
    div_ge    = !div_diff[XLEN+1];
    div_rem   = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
    prod_s    = neg_res ? -acc : acc;
    quo_s     = neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_s     = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    if (op_q[2])
      sel = op_q[1] ? rem_s : quo_s;
    else if (op_q == 3'd0)
      sel = word_q ? prod_s[XLEN+31:32] : prod_s[XLEN-1:0];
    else
      sel = prod_s[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_next = state;
    if (flush)
      state_next = IDLE;
    else begin
      case (state)
        IDLE: if (in_valid) state_next = special ? DONE : CALC;
        CALC: if (cnt == last) state_next = FIX;
        FIX:  state_next = DONE;
        DONE: if (out_ready) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Word-sized dividends are pre-shifted to the top so 32 steps consume exactly their bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0; opb <= '0; cnt <= '0; last <= '0;
      op_q <= '0; word_q <= 1'b0; neg_res <= 1'b0; neg_rem <= 1'b0;
      pc_q <= '0; result <= '0; pc_out <= '0;
    end else if (accept) begin
      op_q    <= op;
      word_q  <= word;
      pc_q    <= pc_in;
      cnt     <= '0;
      last    <= word ? CNT_W'(31) : CNT_W'(XLEN-1);
      neg_res <= neg1 ^ neg2;
      neg_rem <= neg1;
      if (is_div) begin
        acc <= {{XLEN{1'b0}}, (word ? {mag1[XLEN-33:0], 32'b0} : mag1)};
        opb <= mag2;
      end else begin
        acc <= {{XLEN{1'b0}}, mag2};
        opb <= mag1;
      end
      if (special) begin
        result <= spec_res;
        pc_out <= pc_in;
      end
    end else if (state == CALC) begin
      cnt <= cnt + 1'b1;
      if (op_q[2]) acc <= {div_rem, acc[XLEN-2:0], div_ge};
      else         acc <= {mul_hi, acc[XLEN-1:1]};
    end else if (state == FIX) begin
      result <= word_q ? {{(XLEN-32){sel[31]}}, sel[31:0]} : sel;
      pc_out <= pc_q;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed-vector bench for ex_muldiv: latency, special cases, backpressure and flush.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = 3'd0;
  logic        word = 1'b0;
  logic [63:0] src1 = '0, src2 = '0, pc_in = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] result, pc_out;
  logic        busy;

  int checks = 0;
  int errors = 0;

  ex_muldiv #(.XLEN(64), .CNT_W(7)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .word(word), .src1(src1), .src2(src2), .pc_in(pc_in),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .pc_out(pc_out), .busy(busy)
  );

  always #5 clk = ~clk;

  // Issues one op from IDLE and reports cycles until out_valid (-1 on timeout).
  task automatic run_op(input logic [2:0] o, input logic w, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] p, output int lat, output logic [63:0] r, output logic [63:0] pco);
    op = o; word = w; src1 = a; src2 = b; pc_in = p; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) lat = -1;
    r = result;
    pco = pc_out;
    if (out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; op = 3'd0; src1 = 64'd5; src2 = 64'd5;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_ctl out_valid=%b busy=%b want 0 0", out_valid, busy);
    end
    checks++;
    if (result !== 64'd0 || pc_out !== 64'd0) begin
      errors++; $display("[TB] FAIL reset_data result=%h pc_out=%h want 0 0", result, pc_out);
    end
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_release in_ready=%b busy=%b want 1 0", in_ready, busy);
    end
  endtask

  task automatic test_mul();
    int lat; logic [63:0] r, pco;
    run_op(3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'h1000, lat, r, pco);
    checks++;
    if (lat != 66) begin errors++; $display("[TB] FAIL mul_latency got=%0d want=66", lat); end
    checks++;
    if (r !== 64'hFFFF_FFFF_FFFF_FFEB) begin errors++; $display("[TB] FAIL mul_result got=%h want=ffffffffffffffeb", r); end
    checks++;
    if (pco !== 64'h1000) begin errors++; $display("[TB] FAIL mul_pc got=%h want=1000", pco); end
    run_op(3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'h1004, lat, r, pco);
    checks++;
    if (r !== 64'd1) begin errors++; $display("[TB] FAIL mulhu_result got=%h want=1", r); end
    run_op(3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'h1008, lat, r, pco);
    checks++;
    if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("[TB] FAIL mulh_result got=%h want=all ones", r); end
    run_op(3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'h100C, lat, r, pco);
    checks++;
    if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("[TB] FAIL mulhsu_result got=%h want=all ones", r); end
    run_op(3'd0, 1'b1, 64'h0000_0000_0001_0000, 64'h0000_0000_0000_8000, 64'h1010, lat, r, pco);
    checks++;
    if (lat != 34 || r !== 64'hFFFF_FFFF_8000_0000) begin
      errors++; $display("[TB] FAIL mulw lat=%0d result=%h want 34 ffffffff80000000", lat, r);
    end
  endtask

  task automatic test_special();
    int lat; logic [63:0] r, pco;
    run_op(3'd5, 1'b0, 64'd100, 64'd0, 64'h2000, lat, r, pco);
    checks++;
    if (lat != 1 || r !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++; $display("[TB] FAIL divu_zero lat=%0d result=%h want 1 all ones", lat, r);
    end
    run_op(3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 64'h2004, lat, r, pco);
    checks++;
    if (lat != 1 || r !== 64'hFFFF_FFFF_FFFF_FFF9) begin
      errors++; $display("[TB] FAIL rem_zero lat=%0d result=%h want 1 fffffffffffffff9", lat, r);
    end
    run_op(3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2008, lat, r, pco);
    checks++;
    if (lat != 1 || r !== 64'h8000_0000_0000_0000) begin
      errors++; $display("[TB] FAIL div_ovf lat=%0d result=%h want 1 8000000000000000", lat, r);
    end
    run_op(3'd6, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h200C, lat, r, pco);
    checks++;
    if (r !== 64'd0) begin errors++; $display("[TB] FAIL rem_ovf result=%h want 0", r); end
    run_op(3'd7, 1'b1, 64'h0000_0000_8000_0001, 64'd0, 64'h2010, lat, r, pco);
    checks++;
    if (r !== 64'hFFFF_FFFF_8000_0001) begin errors++; $display("[TB] FAIL remuw_zero result=%h want ffffffff80000001", r); end
  endtask

  task automatic test_divide();
    int lat; logic [63:0] r, pco;
    run_op(3'd4, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'h3000, lat, r, pco);
    checks++;
    if (lat != 34) begin errors++; $display("[TB] FAIL divw_latency got=%0d want=34", lat); end
    checks++;
    if (r !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("[TB] FAIL divw_result got=%h want=fffffffffffffffd", r); end
    run_op(3'd6, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'h3004, lat, r, pco);
    checks++;
    if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("[TB] FAIL remw_result got=%h want=all ones", r); end
    run_op(3'd4, 1'b0, 64'd1000, 64'hFFFF_FFFF_FFFF_FFF9, 64'h3008, lat, r, pco);
    checks++;
    if (lat != 66 || r !== 64'hFFFF_FFFF_FFFF_FF72) begin
      errors++; $display("[TB] FAIL div_signed lat=%0d result=%h want 66 ffffffffffffff72", lat, r);
    end
    run_op(3'd6, 1'b0, 64'd1000, 64'hFFFF_FFFF_FFFF_FFF9, 64'h300C, lat, r, pco);
    checks++;
    if (r !== 64'd6) begin errors++; $display("[TB] FAIL rem_signed result=%h want 6", r); end
    run_op(3'd5, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd16, 64'h3010, lat, r, pco);
    checks++;
    if (r !== 64'h0FFF_FFFF_FFFF_FFFF) begin errors++; $display("[TB] FAIL divu_large result=%h want 0fffffffffffffff", r); end
  endtask

  task automatic test_back_to_back();
    int lat; int bad; logic [63:0] r, pco;
    out_ready = 1'b0;
    op = 3'd5; word = 1'b0; src1 = 64'd100; src2 = 64'd0; pc_in = 64'h4000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid got=%b want=1", out_valid); end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (result !== 64'hFFFF_FFFF_FFFF_FFFF || pc_out !== 64'h4000 || out_valid !== 1'b1
          || in_ready !== 1'b0 || busy !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("[TB] FAIL bp_hold unstable_cycles=%0d want=0", bad); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL bp_release out_valid=%b in_ready=%b busy=%b want 0 1 0", out_valid, in_ready, busy);
    end
    run_op(3'd0, 1'b0, 64'd5, 64'd6, 64'h4004, lat, r, pco);
    checks++;
    if (lat != 66 || r !== 64'd30 || pco !== 64'h4004) begin
      errors++; $display("[TB] FAIL b2b_mul lat=%0d result=%h pc=%h want 66 1e 4004", lat, r, pco);
    end
  endtask

  task automatic test_flush();
    int lat; int cyc; int seen; logic [63:0] r, pco;
    op = 3'd4; word = 1'b0; src1 = 64'd1000; src2 = 64'd7; pc_in = 64'h5000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    while (cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL flush_abort in_ready=%b busy=%b out_valid=%b want 1 0 0", in_ready, busy, out_valid);
    end
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("[TB] FAIL flush_no_result valid_cycles=%0d want=0", seen); end
    op = 3'd0; src1 = 64'd9; src2 = 64'd9; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_blocks_accept busy=%b want=0", busy); end
    run_op(3'd0, 1'b0, 64'd3, 64'd4, 64'h5004, lat, r, pco);
    checks++;
    if (lat != 66 || r !== 64'd12 || pco !== 64'h5004) begin
      errors++; $display("[TB] FAIL flush_then_mul lat=%0d result=%h pc=%h want 66 c 5004", lat, r, pco);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_special();
    test_divide();
    test_back_to_back();
    test_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
